bwn_conv3x3_stream: RTL and testbench

//  Parametrised streaming 3x3 binary-weight (+/-1) convolution for the BWN datapath, next generation of the fixed 16-pixel conv stage.

---
 rtl/bwn_conv3x3_stream_if.sv | 26 ++
 rtl/bwn_conv3x3_stream.sv | 198 +++++++++++++++++++
 tb/tb_bwn_conv3x3_stream.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bwn_conv3x3_stream_if.sv
// Pixel-in / result-out signal bundle for the streaming 3x3 binary-weight convolution.
// The slave side is the convolution block; the master side is whoever feeds pixels and takes results.
interface bwn_conv3x3_stream_if #(
    parameter int WL     = 8,
    parameter int OUT_WL = WL + 4
);
    logic                     i_start;
    logic                     i_valid;
    logic signed [WL-1:0]     i_data;
    logic        [8:0]        i_weight;
    logic signed [OUT_WL-1:0] i_bias;
    logic                     o_valid;
    logic signed [OUT_WL-1:0] o_data;
    logic                     o_done;
    logic                     o_busy;

    modport slave (
        input  i_start, i_valid, i_data, i_weight, i_bias,
        output o_valid, o_data, o_done, o_busy
    );

    modport master (
        output i_start, i_valid, i_data, i_weight, i_bias,
        input  o_valid, o_data, o_done, o_busy
    );
endinterface

// File: rtl/bwn_conv3x3_stream.sv
// Streaming 3x3 binary-weight (+/-1) convolution over a raster pixel stream with
// per-frame latched signs/bias, saturated output and a frame-done pulse.
//  state  | meaning
//  S_IDLE | no frame active; pixels without i_start are ignored
//  S_RUN  | frame in progress; every valid pixel is accepted
module bwn_conv3x3_stream #(
    parameter int WL     = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int OUT_WL = WL + 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    bwn_conv3x3_stream_if.slave io_bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = WL + 6;
    localparam logic [CW-1:0]        COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_H - 1);
    localparam logic signed [SW-1:0] SAT_MAX  = SW'((2 ** (OUT_WL - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_busy;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_win_full;
    logic [CW-1:0]            w_col;
    logic [RW-1:0]            w_row;
    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic signed [WL-1:0]     r_win [9];
    logic signed [WL-1:0]     r_lb1 [IMG_W];
    logic signed [WL-1:0]     r_lb2 [IMG_W];
    logic [8:0]               r_weight;
    logic signed [OUT_WL-1:0] r_bias;
    logic                     r_win_vld;
    logic                     r_win_last;
    logic signed [SW-1:0]     w_tap;
    logic signed [SW-1:0]     w_sum;
    logic signed [OUT_WL-1:0] w_sat;
    logic                     r_o_valid;
    logic                     r_o_done;
    logic signed [OUT_WL-1:0] r_o_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (io_bus.i_start) begin
                    w_state_nxt = S_RUN;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state == S_RUN);
        w_accept = io_bus.i_valid & (w_busy | io_bus.i_start);
    end

    // A start pulse makes the pixel on the same cycle position (0,0) of the new frame.
    assign w_col      = io_bus.i_start ? '0 : r_col;
    assign w_row      = io_bus.i_start ? '0 : r_row;
    assign w_last     = w_accept & (w_col == COL_LAST) & (w_row == ROW_LAST);
    assign w_win_full = w_accept & (w_col >= CW'(2)) & (w_row >= RW'(2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end else if (io_bus.i_start) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_weight <= '0;
            r_bias   <= '0;
        end else if (io_bus.i_start) begin
            r_weight <= io_bus.i_weight;
            r_bias   <= io_bus.i_bias;
        end
    end

    // Window index k matches weight bit k: 0..2 current row, 3..5 row above, 6..8 two rows above.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
            for (int k = 0; k < IMG_W; k++) begin
                r_lb1[k] <= '0;
                r_lb2[k] <= '0;
            end
        end else if (io_bus.i_start) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
            for (int k = 0; k < IMG_W; k++) begin
                r_lb1[k] <= '0;
                r_lb2[k] <= '0;
            end
            if (io_bus.i_valid) begin
                r_win[0] <= io_bus.i_data;
                r_lb1[0] <= io_bus.i_data;
            end
        end else if (w_accept) begin
            r_win[0] <= io_bus.i_data;
            r_win[1] <= r_win[0];
            r_win[2] <= r_win[1];
            r_win[3] <= r_lb1[IMG_W-1];
            r_win[4] <= r_win[3];
            r_win[5] <= r_win[4];
            r_win[6] <= r_lb2[IMG_W-1];
            r_win[7] <= r_win[6];
            r_win[8] <= r_win[7];
            r_lb1[0] <= io_bus.i_data;
            r_lb2[0] <= r_lb1[IMG_W-1];
            for (int k = 1; k < IMG_W; k++) begin
                r_lb1[k] <= r_lb1[k-1];
                r_lb2[k] <= r_lb2[k-1];
            end
        end
    end

    always_comb begin
        w_tap = '0;
        w_sum = {{(SW-OUT_WL){r_bias[OUT_WL-1]}}, r_bias};
        for (int k = 0; k < 9; k++) begin
            w_tap = {{(SW-WL){r_win[k][WL-1]}}, r_win[k]};
            w_sum = r_weight[k] ? (w_sum + w_tap) : (w_sum - w_tap);
        end
    end

    always_comb begin
        if (w_sum > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_WL-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_WL-1:0];
        end else begin
            w_sat = w_sum[OUT_WL-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win_vld  <= 1'b0;
            r_win_last <= 1'b0;
            r_o_valid  <= 1'b0;
            r_o_done   <= 1'b0;
            r_o_data   <= '0;
        end else begin
            r_win_vld  <= w_win_full;
            r_win_last <= w_last;
            r_o_valid  <= r_win_vld;
            r_o_done   <= r_win_vld & r_win_last;
            if (r_win_vld) begin
                r_o_data <= w_sat;
            end
        end
    end

    assign io_bus.o_valid = r_o_valid;
    assign io_bus.o_data  = r_o_data;
    assign io_bus.o_done  = r_o_done;
    assign io_bus.o_busy  = w_busy;
endmodule

// File: tb/tb_bwn_conv3x3_stream.sv
// Directed bench for bwn_conv3x3_stream: table of whole frames plus restart and mid-frame reset sequences.
module tb_bwn_conv3x3_stream;
    localparam int WL     = 8;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 16;
    localparam int OUT_WL = WL + 4;
    localparam int N_OUT  = (IMG_W - 2) * (IMG_H - 2);
    localparam int SAT_HI = (1 << (OUT_WL - 1)) - 1;
    localparam int SAT_LO = -(1 << (OUT_WL - 1));

    typedef struct {
        string      name;
        int         mode;
        int         pix;
        logic [8:0] w;
        int         bias;
        bit         gaps;
        int         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   cap_data[$];
    bit   cap_done[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    bwn_conv3x3_stream_if #(.WL(WL), .OUT_WL(OUT_WL)) bus ();

    bwn_conv3x3_stream #(
        .WL(WL), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_WL(OUT_WL)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always @(negedge clk) begin
        if (bus.o_valid) begin
            cap_data.push_back(int'(bus.o_data));
            cap_done.push_back(bus.o_done);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mode 0: constant pixel; mode 1: ramp (r*IMG_W+c) mod 128
    function automatic int pixval(input int mode, input int pix, input int r, input int c);
        if (mode == 0) return pix;
        return (r * IMG_W + c) % 128;
    endfunction

    function automatic int model(input int mode, input int pix, input logic [8:0] w,
                                 input int bias, input int r, input int c);
        int s;
        int v;
        s = bias;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                v = pixval(mode, pix, r - dr, c - dc);
                s = w[dr*3 + dc] ? s + v : s - v;
            end
        end
        if (s > SAT_HI) s = SAT_HI;
        if (s < SAT_LO) s = SAT_LO;
        return s;
    endfunction

    task automatic start_frame(input int mode, input int pix, input logic [8:0] w, input int bias);
        bus.i_start  = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_weight = w;
        bus.i_bias   = OUT_WL'(bias);
        bus.i_data   = WL'(pixval(mode, pix, 0, 0));
        @(posedge clk); #1;
        bus.i_start  = 1'b0;
        bus.i_weight = ~w;
        bus.i_bias   = OUT_WL'(bias + 777);
    endtask

    task automatic drive_pixels(input int mode, input int pix, input int first, input int last,
                                input bit gaps);
        int g;
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    bus.i_valid = 1'b0;
                    bus.i_data  = WL'($urandom);
                    @(posedge clk); #1;
                end
            end
            bus.i_valid = 1'b1;
            bus.i_data  = WL'(pixval(mode, pix, i / IMG_W, i % IMG_W));
            if (i == 128) check("busy_mid", int'(bus.o_busy), 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_full(input int mode, input int pix, input logic [8:0] w, input int bias,
                            input bit gaps);
        start_frame(mode, pix, w, bias);
        drive_pixels(mode, pix, 1, IMG_W * IMG_H - 1, gaps);
        bus.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int skip, input int mode, input int pix,
                               input logic [8:0] w, input int bias, input int exp_const);
        int r;
        int c;
        int e;
        check($sformatf("%s_count", name), cap_data.size() - skip, N_OUT);
        for (int k = 0; k < N_OUT && skip + k < cap_data.size(); k++) begin
            r = 2 + k / (IMG_W - 2);
            c = 2 + k % (IMG_W - 2);
            e = (mode == 0) ? exp_const : model(mode, pix, w, bias, r, c);
            check($sformatf("%s_data[%0d]", name, k), cap_data[skip+k], e);
            check($sformatf("%s_done[%0d]", name, k), int'(cap_done[skip+k]), (k == N_OUT - 1) ? 1 : 0);
        end
    endtask

    initial begin
        tbl[0] = '{"ones_pos",   0,    1, 9'h1FF,    0, 1'b0,     9};
        tbl[1] = '{"ones_neg",   0,    1, 9'h000,    5, 1'b0,    -4};
        tbl[2] = '{"min_pos",    0, -128, 9'h1FF,    0, 1'b0, -1152};
        tbl[3] = '{"sat_hi",     0,  127, 9'h1FF, 2047, 1'b0,  2047};
        tbl[4] = '{"sat_lo",     0, -128, 9'h1FF, -2048, 1'b0, -2048};
        tbl[5] = '{"sat_lo_neg", 0,  127, 9'h000, -2048, 1'b0, -2048};
        tbl[6] = '{"ramp",       1,    0, 9'h155,    0, 1'b0,     0};
        tbl[7] = '{"ramp_gaps",  1,    0, 9'h155,    0, 1'b1,     0};
        tbl[8] = '{"ramp_bias",  1,    0, 9'h0F3, -100, 1'b1,     0};

        rst          = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_weight = '0;
        bus.i_bias   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_data",  int'(bus.o_data), 0);
        check("rst_done",  int'(bus.o_done), 0);
        check("rst_busy",  int'(bus.o_busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 9; t++) begin
            cap_data.delete();
            cap_done.delete();
            run_full(tbl[t].mode, tbl[t].pix, tbl[t].w, tbl[t].bias, tbl[t].gaps);
            check_frame(tbl[t].name, 0, tbl[t].mode, tbl[t].pix, tbl[t].w, tbl[t].bias, tbl[t].exp);
            check($sformatf("%s_busy_end", tbl[t].name), int'(bus.o_busy), 0);
        end

        // Valid pixels in IDLE without a start pulse must not advance anything.
        cap_data.delete();
        cap_done.delete();
        repeat (6) begin
            bus.i_valid = 1'b1;
            bus.i_data  = WL'(8'h11);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ignored", cap_data.size(), 0);
        check("idle_busy", int'(bus.o_busy), 0);

        // Restart at pixel 100, back to back with the old frame's pixel 99.
        cap_data.delete();
        cap_done.delete();
        start_frame(0, 1, 9'h1FF, 0);
        drive_pixels(0, 1, 1, 99, 1'b0);
        run_full(0, 2, 9'h1FF, 0, 1'b0);
        check("restart_old_count", (cap_data.size() >= 58) ? 58 : cap_data.size(), 58);
        for (int k = 0; k < 58 && k < cap_data.size(); k++) begin
            check($sformatf("restart_old_data[%0d]", k), cap_data[k], 9);
            check($sformatf("restart_old_done[%0d]", k), int'(cap_done[k]), 0);
        end
        check_frame("restart_new", 58, 0, 2, 9'h1FF, 0, 18);

        // Reset in the middle of a frame.
        cap_data.delete();
        cap_done.delete();
        start_frame(0, 1, 9'h1FF, 0);
        drive_pixels(0, 1, 1, 149, 1'b0);
        check("pre_rst_valid", int'(bus.o_valid), 1);
        check("pre_rst_data", int'(bus.o_data), 9);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus.o_valid), 0);
        check("mid_rst_data",  int'(bus.o_data), 0);
        check("mid_rst_done",  int'(bus.o_done), 0);
        check("mid_rst_busy",  int'(bus.o_busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cap_data.delete();
        cap_done.delete();
        repeat (10) begin
            bus.i_valid = 1'b1;
            bus.i_data  = WL'(8'h01);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_ignored", cap_data.size(), 0);
        check("post_rst_busy", int'(bus.o_busy), 0);
        cap_data.delete();
        cap_done.delete();
        run_full(0, 1, 9'h1FF, 0, 1'b0);
        check_frame("post_rst_frame", 0, 0, 1, 9'h1FF, 0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
